// File: rtl/stepper_move_ctrl_if.sv
// stepper_move_ctrl_if: command, status and coil-drive bundle for stepper_move_ctrl
interface stepper_move_ctrl_if #(
    parameter int POS_W = 16,
    parameter int DIV_W = 16
);
    logic                    START, ABORT, HALF_FULL;
    logic signed [POS_W-1:0] TARGET, POS;
    logic        [DIV_W-1:0] DIV;
    logic                    A, B, C, D, INH1, INH2;
    logic                    BUSY, DONE, DIR;

    modport master (
        output START, ABORT, TARGET, DIV, HALF_FULL,
        input  A, B, C, D, INH1, INH2, POS, BUSY, DONE, DIR
    );
    modport slave (
        input  START, ABORT, TARGET, DIV, HALF_FULL,
        output A, B, C, D, INH1, INH2, POS, BUSY, DONE, DIR
    );
endinterface

// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl: move-to-target stepper controller with rate divider, abort and BUSY/DONE.
// Optional STEP_IDLE_OFF_EN de-energises INH1/INH2 after IDLE_OFF_CYC idle clocks.
module stepper_move_ctrl #(
    parameter int POS_W        = 16,
    parameter int DIV_W        = 16,
    parameter int IDLE_OFF_CYC = 1000
) (
    input logic CLK,
    input logic RESET,
    stepper_move_ctrl_if.slave bus
);
    typedef enum logic {IDLE, MOVE} state_t;

    localparam logic [5:0] TBL [8] = '{6'b010111, 6'b001101, 6'b100111, 6'b100010,
                                       6'b101011, 6'b001001, 6'b011011, 6'b010010};

    state_t                  state, state_n;
    logic              [2:0] phase, phase_n;
    logic signed [POS_W-1:0] pos, pos_n, target, target_n;
    logic        [DIV_W-1:0] count, count_n, div, div_n;
    logic                    half, half_n, dir, dir_n, done, done_n, off;
    logic              [5:0] coil;

    if (IDLE_OFF_CYC < 1) begin : g_bad_cfg
        $error("IDLE_OFF_CYC must be at least 1");
    end

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        pos_n    = pos;
        target_n = target;
        div_n    = div;
        half_n   = half;
        dir_n    = dir;
        count_n  = count;
        done_n   = 1'b0;
        if (state == IDLE) begin
            if (bus.START && bus.TARGET == pos)
                done_n = 1'b1;
            else if (bus.START) begin
                target_n = bus.TARGET;
                div_n    = bus.DIV;
                half_n   = bus.HALF_FULL;
                dir_n    = bus.TARGET > pos;
                count_n  = bus.DIV;
                state_n  = MOVE;
            end
        end else if (bus.ABORT) begin
            state_n = IDLE;
            done_n  = 1'b1;
        end else if (count != '0)
            count_n = count - 1'b1;
        else begin
            phase_n = dir ? phase + (half ? 3'd1 : 3'd2) : phase - (half ? 3'd1 : 3'd2);
            pos_n   = dir ? pos + 1'b1 : pos - 1'b1;
            count_n = div;
            if (pos_n == target) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end
    end

    // coil drive is registered from the next phase so it moves on the same edge as phase
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            phase  <= '0;
            pos    <= '0;
            target <= '0;
            div    <= '0;
            half   <= 1'b0;
            dir    <= 1'b1;
            count  <= '0;
            done   <= 1'b0;
            coil   <= TBL[0];
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            pos    <= pos_n;
            target <= target_n;
            div    <= div_n;
            half   <= half_n;
            dir    <= dir_n;
            count  <= count_n;
            done   <= done_n;
            coil   <= TBL[phase_n];
        end
    end

`ifdef STEP_IDLE_OFF_EN
    localparam int IW = $clog2(IDLE_OFF_CYC + 1);
    logic [IW-1:0] idle_cnt;

    // saturating idle counter; cleared in MOVE and by any START
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            idle_cnt <= '0;
        else
            idle_cnt <= (state == MOVE || bus.START) ? '0 :
                        (idle_cnt == IW'(IDLE_OFF_CYC)) ? idle_cnt : idle_cnt + 1'b1;
    end

    assign off = idle_cnt == IW'(IDLE_OFF_CYC);
`else
    assign off = 1'b0;
`endif

    assign {bus.A, bus.B, bus.C, bus.D} = coil[5:2];
    assign bus.INH1 = coil[1] & ~off;
    assign bus.INH2 = coil[0] & ~off;
    assign bus.POS  = pos;
    assign bus.BUSY = state == MOVE;
    assign bus.DONE = done;
    assign bus.DIR  = dir;
endmodule

// File: doc/stepper_move_ctrl.md
Name: stepper_move_ctrl

Overview:
- Parametrised stepper-motor position controller: accepts a signed target position and a step period, then drives the 8-phase coil sequence until the target is reached.
- Adds to the free-running stepper FSM: a programmable step-rate divider, a signed position counter, move-to-target, abort, and a BUSY/DONE handshake.
- Sits between the command logic and the motor driver or emulator; output encoding is unchanged so existing emulator benches connect directly.

Parameters:
- POS_W, 16, width of TARGET and POS (two's complement).
- DIV_W, 16, width of DIV.
- IDLE_OFF_CYC, 1000, idle clocks before coil power-down (used only with STEP_IDLE_OFF_EN).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  move request; sampled only in IDLE.
- ABORT  in  1  stop the current move.
- TARGET  in  POS_W  signed target position, latched on START.
- DIV  in  DIV_W  step period minus 1, in clocks; latched on START.
- HALF_FULL  in  1  1 = half step (phase ±1), 0 = full step (phase ±2); latched on START.
- A, B, C, D, INH1, INH2  out  1 each  coil drive, registered.
- POS  out  POS_W  current signed position.
- BUSY  out  1  high while in MOVE.
- DONE  out  1  one-cycle pulse when a move ends (reached, zero-distance or aborted).
- DIR  out  1  1 = up, 0 = down; direction of the current or last move.

Behaviour:
- Reset (async, RESET=0): phase=0, POS=0, BUSY=0, DONE=0, DIR=1, count=0, state IDLE; outputs A B C D INH1 INH2 = 0 1 0 1 1 1.
- Phase to outputs (A B C D INH1 INH2):
  - 0: 010111
  - 1: 001101
  - 2: 100111
  - 3: 100010
  - 4: 101011
  - 5: 001001
  - 6: 011011
  - 7: 010010
- Phase is a 3-bit index that wraps modulo 8. Outputs are registered from the next-phase value, so they change on the same edge as phase.
- State IDLE:
  - START=1 and TARGET==POS: stay in IDLE; DONE=1 next cycle; no step.
  - START=1 and TARGET!=POS: latch TARGET, DIV and HALF_FULL; set DIR = (TARGET > POS, signed); load count=DIV; go to MOVE, with BUSY=1 from the next cycle.
  - ABORT is ignored in IDLE.
- State MOVE, each clock:
  - ABORT=1 (highest priority): go to IDLE; DONE=1; no step on that edge; phase and POS hold.
  - Else count!=0: count decrements by 1.
  - Else step:
    - phase ±1 (half) or ±2 (full), sign set by DIR.
    - POS ±1; POS counts steps, not phases.
    - count reloads DIV.
    - If the new POS == target: go to IDLE, DONE=1 and BUSY=0 on that same edge.
- Step timing: first step occurs DIV+1 clocks after entering MOVE; steps then repeat every DIV+1 clocks. DIV=0 gives one step per clock.
- START is ignored while BUSY=1. TARGET, DIV and HALF_FULL changes during MOVE have no effect.
- POS wraps in two's complement at ±2^(POS_W-1). DIR is fixed at START, so a move always terminates.
- Full mode starting from an odd phase stays on odd phases (single-coil stepping); this is legal, not an error.
- RESET asserted mid-move: immediate return to reset values; no DONE pulse.

Optional Feature:
- Macro: STEP_IDLE_OFF_EN.
- Defined:
  - An idle counter runs in IDLE and clears on any START.
  - Once it reaches IDLE_OFF_CYC, INH1=INH2=0 (coils de-energised); A–D and phase hold.
  - The phase-table INH values return on the edge that accepts START, including a zero-distance START.
- Undefined: INH1/INH2 always follow the phase table; no idle counter is synthesised.

Test Plan:
- Reset, then TARGET=5, DIV=3, HALF_FULL=1, START pulse -> BUSY high; steps at clocks 4, 8, 12, 16, 20 after MOVE entry; phase 0→5; POS=5; DONE one cycle at the 5th step; outputs at phase 5 = 001001.
- From POS=5/phase 5: TARGET=2, DIV=0, HALF_FULL=0 -> DIR=0; 3 consecutive steps; phase 5→3→1→7; POS=2; DONE pulse.
- TARGET equal to POS, START -> no output change; BUSY stays 0; DONE=1 exactly one cycle later.
- TARGET=100, DIV=1; ABORT after the 10th step -> POS=10; no further steps; DONE pulse; BUSY=0; a second START during the move is ignored.
- POS_W=4: from POS=7, TARGET=-8 (down, 15 steps); reset asserted mid-move -> all outputs return to reset values asynchronously; no DONE.
- With STEP_IDLE_OFF_EN and IDLE_OFF_CYC=10: after a move completes, INH1=INH2=0 after 10 idle clocks; a new START restores the table INH values on the accept edge.
